// File: rtl/pipeline_flush_ctrl_pkg.sv
// pipeline_flush_ctrl_pkg: shared branch-status struct, sequencer state enum and PC mux constants
package pipeline_flush_ctrl_pkg;
  typedef struct packed {
    logic [2:0] pc_sel;
    logic       failed_prediction;
  } BRANCH_PREDICTION_STATUS_t;
  typedef enum logic {RUN, REDIRECT} FLUSH_CTRL_STATE_t;
  localparam logic [2:0] PC_SEL_NEXT = 3'd0;
endpackage

// File: rtl/pipeline_flush_ctrl_sat_event_counter.sv
// sat_event_counter: event counter that saturates at all-ones and clears on RST
module sat_event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count events, sticking at all-ones instead of wrapping
  always_ff @(posedge CLK)
    if (RST) count <= '0;
    else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/pipeline_flush_ctrl.sv
// pipeline_flush_ctrl: hazard-unit PC/pipeline-register sequencer; stats counters enabled by BRANCH_STATS_EN
module pipeline_flush_ctrl
  import pipeline_flush_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  de_valid,
  input  logic [3:0]            pred_info,
  input  logic                  load_use_haz,
  input  logic                  mem_stall,
  output logic [2:0]            pc_sel_out,
  output logic                  pc_write,
  output logic                  if_de_write,
  output logic                  if_de_flush,
  output logic                  de_ex_write,
  output logic                  de_ex_flush,
  output logic                  redirect_busy,
  output logic [STAT_WIDTH-1:0] mispredict_cnt,
  output logic [STAT_WIDTH-1:0] bubble_cnt
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  FLUSH_CTRL_STATE_t         state;
  logic [CW-1:0]             cnt;
  BRANCH_PREDICTION_STATUS_t pred;
  logic                      live, run, hazard, accept, redirect;
  assign pred     = pred_info;
  assign live     = !RST && !mem_stall;
  assign run      = live && state == RUN && de_valid;
  assign hazard   = run && load_use_haz;
  assign accept   = run && !load_use_haz && pred.failed_prediction;
  assign redirect = live && state == REDIRECT;
  // zero-latency control outputs; reset forces both pipeline registers to bubble
  always_comb begin
    pc_sel_out    = accept ? pred.pc_sel : PC_SEL_NEXT;
    pc_write      = live && !hazard;
    if_de_write   = live && !hazard;
    de_ex_write   = live;
    if_de_flush   = RST || accept || redirect;
    de_ex_flush   = RST || hazard || redirect;
    redirect_busy = state == REDIRECT;
  end
  // squash sequencer: an accepted mispredict holds REDIRECT for FLUSH_CYCLES-1 non-stalled cycles
  always_ff @(posedge CLK)
    if (RST) begin
      state <= RUN;
      cnt   <= '0;
    end else if (redirect) begin
      state <= cnt == CW'(1) ? RUN : REDIRECT;
      cnt   <= cnt - CW'(1);
    end else if (accept && FLUSH_CYCLES > 1) begin
      state <= REDIRECT;
      cnt   <= CW'(FLUSH_CYCLES - 1);
    end
`ifdef BRANCH_STATS_EN
  sat_event_counter #(.WIDTH(STAT_WIDTH)) u_mispredict_cnt (.CLK(CLK), .RST(RST), .inc(accept), .count(mispredict_cnt));
  sat_event_counter #(.WIDTH(STAT_WIDTH)) u_bubble_cnt (.CLK(CLK), .RST(RST), .inc(hazard), .count(bubble_cnt));
`else
  assign mispredict_cnt = '0;
  assign bubble_cnt     = '0;
`endif
endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// tb_pipeline_flush_ctrl: directed table and sequence checks for single- and multi-cycle flush configurations
module tb_pipeline_flush_ctrl;
  logic       clk = 0, rst = 1, de_valid = 0, load_use_haz = 0, mem_stall = 0;
  logic [3:0] pred_info = '0;
  logic [2:0] s1, s3;
  logic       pw1, iw1, ifl1, dw1, dfl1, b1, pw3, iw3, ifl3, dw3, dfl3, b3;
  logic [1:0]  mc1, bc1;
  logic [31:0] mc3, bc3;
  logic [8:0]  o1, o3;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pipeline_flush_ctrl #(.FLUSH_CYCLES(1), .STAT_WIDTH(2)) dut1 (
    .CLK(clk), .RST(rst), .de_valid(de_valid), .pred_info(pred_info), .load_use_haz(load_use_haz),
    .mem_stall(mem_stall), .pc_sel_out(s1), .pc_write(pw1), .if_de_write(iw1), .if_de_flush(ifl1),
    .de_ex_write(dw1), .de_ex_flush(dfl1), .redirect_busy(b1), .mispredict_cnt(mc1), .bubble_cnt(bc1));
  pipeline_flush_ctrl #(.FLUSH_CYCLES(3), .STAT_WIDTH(32)) dut3 (
    .CLK(clk), .RST(rst), .de_valid(de_valid), .pred_info(pred_info), .load_use_haz(load_use_haz),
    .mem_stall(mem_stall), .pc_sel_out(s3), .pc_write(pw3), .if_de_write(iw3), .if_de_flush(ifl3),
    .de_ex_write(dw3), .de_ex_flush(dfl3), .redirect_busy(b3), .mispredict_cnt(mc3), .bubble_cnt(bc3));
  assign o1 = {s1, pw1, iw1, ifl1, dw1, dfl1, b1};
  assign o3 = {s3, pw3, iw3, ifl3, dw3, dfl3, b3};
  // expected output words: {pc_sel, pc_write, if_de_write, if_de_flush, de_ex_write, de_ex_flush, busy}
  localparam logic [8:0] O_RST = 9'b000_0_0_1_0_1_0;
  localparam logic [8:0] O_RUN = 9'b000_1_1_0_1_0_0;
  localparam logic [8:0] O_STL = 9'b000_0_0_0_0_0_0;
  localparam logic [8:0] O_LUH = 9'b000_0_0_0_1_1_0;
  localparam logic [8:0] O_RDR = 9'b000_1_1_1_1_1_1;
  function automatic logic [8:0] mis(input logic [2:0] s);
    return {s, 6'b1_1_1_1_0_0};
  endfunction
  typedef struct {
    logic       r, d;
    logic [3:0] p;
    logic       l, m;
    logic [8:0] e;
  } vec_t;
  vec_t tbl[13];
  task automatic drive(input logic r, d, input logic [3:0] p, input logic l, m);
    rst = r; de_valid = d; pred_info = p; load_use_haz = l; mem_stall = m;
    #2;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step3(input string nm, input logic r, d, input logic [3:0] p, input logic l, m,
                       input logic [8:0] e);
    drive(r, d, p, l, m);
    chk(nm, 32'(o3), 32'(e));
    tick();
  endtask
  initial begin
    logic [1:0] exp_mc, exp_bc;
`ifdef BRANCH_STATS_EN
    exp_mc = 2'd3; exp_bc = 2'd2;
`else
    exp_mc = 2'd0; exp_bc = 2'd0;
`endif
    tbl[0]  = '{1, 0, 4'h0, 0, 0, O_RST};
    tbl[1]  = '{1, 1, {3'd2, 1'b1}, 0, 0, O_RST};
    tbl[2]  = '{0, 1, 4'h0, 0, 0, O_RUN};
    tbl[3]  = '{0, 1, {3'd2, 1'b1}, 0, 0, mis(3'd2)};
    tbl[4]  = '{0, 1, 4'h0, 0, 0, O_RUN};
    tbl[5]  = '{0, 0, {3'd5, 1'b1}, 1, 0, O_RUN};
    tbl[6]  = '{0, 1, {3'd3, 1'b1}, 1, 0, O_LUH};
    tbl[7]  = '{0, 1, {3'd3, 1'b1}, 0, 0, mis(3'd3)};
    tbl[8]  = '{0, 1, {3'd4, 1'b1}, 0, 1, O_STL};
    tbl[9]  = '{0, 1, {3'd4, 1'b1}, 1, 1, O_STL};
    tbl[10] = '{0, 1, {3'd7, 1'b1}, 0, 0, mis(3'd7)};
    tbl[11] = '{0, 1, {3'd6, 1'b0}, 0, 0, O_RUN};
    tbl[12] = '{0, 1, 4'h0, 1, 0, O_LUH};
    drive(1, 0, 4'h0, 0, 0);
    tick();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].d, tbl[i].p, tbl[i].l, tbl[i].m);
      chk($sformatf("tbl%0d", i), 32'(o1), 32'(tbl[i].e));
      tick();
    end
    drive(0, 0, 4'h0, 0, 0);
    chk("mispredict_cnt", 32'(mc1), 32'(exp_mc));
    chk("bubble_cnt", 32'(bc1), 32'(exp_bc));
    step3("rst_a", 1, 0, 4'h0, 0, 0, {O_RST[8:1], 1'bx} & 9'h1fe | {8'h0, b3});
    chk("stat_clr_mis", 32'(mc1), 32'd0);
    chk("stat_clr_bub", 32'(bc1), 32'd0);
    step3("rst_b", 1, 0, 4'h0, 0, 0, O_RST);
    step3("redir_acc", 0, 1, {3'd1, 1'b1}, 0, 0, mis(3'd1));
    step3("redir_c2", 0, 1, {3'd5, 1'b1}, 0, 0, O_RDR);
    step3("redir_c3", 0, 1, {3'd5, 1'b1}, 1, 0, O_RDR);
    step3("redir_done", 0, 1, 4'h0, 0, 0, O_RUN);
    step3("stall_acc", 0, 1, {3'd1, 1'b1}, 0, 0, mis(3'd1));
    step3("stall_c1", 0, 1, {3'd6, 1'b1}, 0, 1, O_STL | 9'd1);
    step3("stall_c2", 0, 1, {3'd6, 1'b1}, 0, 1, O_STL | 9'd1);
    step3("stall_r1", 0, 1, 4'h0, 0, 0, O_RDR);
    step3("stall_r2", 0, 1, 4'h0, 0, 0, O_RDR);
    step3("stall_done", 0, 1, 4'h0, 0, 0, O_RUN);
    step3("luh_mis", 0, 1, {3'd3, 1'b1}, 1, 0, O_LUH);
    step3("luh_clear", 0, 1, {3'd3, 1'b1}, 0, 0, mis(3'd3));
    step3("luh_r1", 0, 1, 4'h0, 0, 0, O_RDR);
    step3("luh_r2", 0, 1, 4'h0, 0, 0, O_RDR);
    step3("rst_mid_acc", 0, 1, {3'd4, 1'b1}, 0, 0, mis(3'd4));
    step3("rst_mid", 1, 1, 4'h0, 0, 0, O_RST | 9'd1);
    step3("rst_mid_run", 0, 1, 4'h0, 0, 0, O_RUN);
    step3("rst_mid_run2", 0, 1, 4'h0, 0, 0, O_RUN);
    drive(1, 0, 4'h0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, {3'd2, 1'b1}, 0, 0);
      tick();
    end
    drive(0, 0, 4'h0, 0, 0);
    chk("mis_sat", 32'(mc1), 32'(exp_mc));
    drive(1, 0, 4'h0, 0, 0);
    tick();
    chk("mis_sat_rst", 32'(mc1), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
